// File: rtl/operand_fetch_stage.sv
// Operand fetch / issue stage: reads the register file, forwards from EX, tracks
// pending long-latency destinations and holds one instruction for the execute unit.
module operand_fetch_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int REG_DEPTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [ADDR_WIDTH-1:0] rs1_i,
  input  logic [ADDR_WIDTH-1:0] rs2_i,
  input  logic [ADDR_WIDTH-1:0] rd_i,
  input  logic                  rd_we_i,
  input  logic                  long_i,
  output logic [ADDR_WIDTH-1:0] rf_addr_1_o,
  output logic [ADDR_WIDTH-1:0] rf_addr_2_o,
  input  logic [DATA_WIDTH-1:0] rf_data_1_i,
  input  logic [DATA_WIDTH-1:0] rf_data_2_i,
  input  logic                  ex_fwd_we_i,
  input  logic [ADDR_WIDTH-1:0] ex_fwd_addr_i,
  input  logic [DATA_WIDTH-1:0] ex_fwd_data_i,
  input  logic                  ll_done_i,
  input  logic [ADDR_WIDTH-1:0] ll_done_addr_i,
  input  logic                  flush_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] op1_o,
  output logic [DATA_WIDTH-1:0] op2_o,
  output logic [ADDR_WIDTH-1:0] rd_o,
  output logic                  rd_we_o,
  output logic                  long_o
);

  logic [REG_DEPTH-1:0]  sb_q;
  logic [REG_DEPTH-1:0]  sb_d;
  logic                  hazard;
  logic                  accept;
  logic                  handshake;
  logic [DATA_WIDTH-1:0] op1_sel;
  logic [DATA_WIDTH-1:0] op2_sel;

  // A completing long op is bypassed; any instruction still held here that writes r blocks.
  function automatic logic busy(input logic [ADDR_WIDTH-1:0] r);
    logic pending;
    logic held;
    pending = sb_q[r] & !(ll_done_i && (ll_done_addr_i == r));
    held    = valid_o & rd_we_o & (rd_o == r);
    return (r != '0) & (pending | held);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] select_op(input logic [ADDR_WIDTH-1:0] idx,
                                                      input logic [DATA_WIDTH-1:0] rf_data);
    logic [DATA_WIDTH-1:0] result;
    if (idx == '0)
      result = '0;
    else if (ex_fwd_we_i && (ex_fwd_addr_i == idx))
      result = ex_fwd_data_i;
    else
      result = rf_data;
    return result;
  endfunction

  assign rf_addr_1_o = rs1_i;
  assign rf_addr_2_o = rs2_i;

  always_comb begin
    hazard    = busy(rs1_i) | busy(rs2_i) | (busy(rd_i) & rd_we_i);
    ready_o   = !flush_i & !hazard & (!valid_o | ready_i);
    accept    = valid_i & ready_o;
    handshake = valid_o & ready_i;
    op1_sel   = select_op(rs1_i, rf_data_1_i);
    op2_sel   = select_op(rs2_i, rf_data_2_i);
  end

  // Set is applied after clear so a same-index collision leaves the bit set.
  always_comb begin
    sb_d = sb_q;
    if (ll_done_i)
      sb_d[ll_done_addr_i] = 1'b0;
    if (handshake && !flush_i && rd_we_o && long_o && (rd_o != '0))
      sb_d[rd_o] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      sb_q    <= '0;
      valid_o <= 1'b0;
      op1_o   <= '0;
      op2_o   <= '0;
      rd_o    <= '0;
      rd_we_o <= 1'b0;
      long_o  <= 1'b0;
    end else begin
      sb_q <= sb_d;
      if (flush_i) begin
        valid_o <= 1'b0;
      end else if (accept) begin
        valid_o <= 1'b1;
        op1_o   <= op1_sel;
        op2_o   <= op2_sel;
        rd_o    <= rd_i;
        rd_we_o <= rd_we_i;
        long_o  <= long_i;
      end else if (handshake) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage: directed issues push expected
// results, a negedge monitor checks each downstream handshake.
module tb_operand_fetch_stage;

  localparam int DW = 64;
  localparam int AW = 5;

  logic          clk_i = 1'b0;
  logic          arst_i;
  logic          valid_i;
  logic          ready_o;
  logic [AW-1:0] rs1_i, rs2_i, rd_i;
  logic          rd_we_i, long_i;
  logic [AW-1:0] rf_addr_1_o, rf_addr_2_o;
  logic [DW-1:0] rf_data_1_i, rf_data_2_i;
  logic          ex_fwd_we_i;
  logic [AW-1:0] ex_fwd_addr_i;
  logic [DW-1:0] ex_fwd_data_i;
  logic          ll_done_i;
  logic [AW-1:0] ll_done_addr_i;
  logic          flush_i;
  logic          valid_o;
  logic          ready_i;
  logic [DW-1:0] op1_o, op2_o;
  logic [AW-1:0] rd_o;
  logic          rd_we_o, long_o;

  typedef struct packed {
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic [AW-1:0] rd;
    logic          we;
    logic          lng;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  operand_fetch_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_DEPTH(32)) dut (
    .clk_i(clk_i), .arst_i(arst_i), .valid_i(valid_i), .ready_o(ready_o),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .rd_we_i(rd_we_i), .long_i(long_i),
    .rf_addr_1_o(rf_addr_1_o), .rf_addr_2_o(rf_addr_2_o),
    .rf_data_1_i(rf_data_1_i), .rf_data_2_i(rf_data_2_i),
    .ex_fwd_we_i(ex_fwd_we_i), .ex_fwd_addr_i(ex_fwd_addr_i), .ex_fwd_data_i(ex_fwd_data_i),
    .ll_done_i(ll_done_i), .ll_done_addr_i(ll_done_addr_i), .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i), .op1_o(op1_o), .op2_o(op2_o),
    .rd_o(rd_o), .rd_we_o(rd_we_o), .long_o(long_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic exp_t mk(input logic [DW-1:0] op1, input logic [DW-1:0] op2,
                              input logic [AW-1:0] rd, input logic we, input logic lng);
    exp_t e;
    e.op1 = op1; e.op2 = op2; e.rd = rd; e.we = we; e.lng = lng;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    n_checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    else
      n_pass++;
  endtask

  task automatic applyStimulus(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                               input logic [AW-1:0] rd, input logic we, input logic lng,
                               input logic [DW-1:0] rf1, input logic [DW-1:0] rf2);
    valid_i = v; rs1_i = rs1; rs2_i = rs2; rd_i = rd; rd_we_i = we; long_i = lng;
    rf_data_1_i = rf1; rf_data_2_i = rf2;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Every handshake must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (!arst_i && valid_o && ready_i) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL unexpected_output: got op1=0x%0h rd=%0d, expected no output", op1_o, rd_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (op1_o !== mon_e.op1 || op2_o !== mon_e.op2 || rd_o !== mon_e.rd ||
            rd_we_o !== mon_e.we || long_o !== mon_e.lng)
          $display("[TB] FAIL handshake_rd%0d: got op1=0x%0h op2=0x%0h rd=%0d we=%b long=%b, expected op1=0x%0h op2=0x%0h rd=%0d we=%b long=%b",
                   mon_e.rd, op1_o, op2_o, rd_o, rd_we_o, long_o,
                   mon_e.op1, mon_e.op2, mon_e.rd, mon_e.we, mon_e.lng);
        else
          n_pass++;
      end
    end
  end

  initial begin
    arst_i = 1'b1; ready_i = 1'b1; flush_i = 1'b0;
    ex_fwd_we_i = 1'b0; ex_fwd_addr_i = '0; ex_fwd_data_i = '0;
    ll_done_i = 1'b0; ll_done_addr_i = '0;
    applyStimulus(0, 0, 0, 0, 0, 0, '0, '0);

    tick();
    @(negedge clk_i);
    checkOutput("rst_valid", valid_o, 0);
    checkOutput("rst_op1", op1_o, 0);
    checkOutput("rst_op2", op2_o, 0);
    checkOutput("rst_rd", rd_o, 0);
    checkOutput("rst_rd_we", rd_we_o, 0);
    checkOutput("rst_long", long_o, 0);
    tick();
    arst_i = 1'b0;

    // Basic issue
    applyStimulus(1, 3, 4, 1, 1, 0, 'h11, 'h22);
    exp_q.push_back(mk('h11, 'h22, 1, 1, 0));
    @(negedge clk_i);
    checkOutput("basic_ready", ready_o, 1);
    checkOutput("rf_addr_1", rf_addr_1_o, 3);
    checkOutput("rf_addr_2", rf_addr_2_o, 4);
    tick();
    valid_i = 1'b0;
    @(negedge clk_i);
    checkOutput("basic_valid", valid_o, 1);
    tick();

    // Short RAW: A writes x5, B reads x5
    applyStimulus(1, 1, 2, 5, 1, 0, 'hA1, 'hA2);
    exp_q.push_back(mk('hA1, 'hA2, 5, 1, 0));
    @(negedge clk_i);
    checkOutput("basic_drop", valid_o, 0);
    checkOutput("raw_a_ready", ready_o, 1);
    tick();
    ready_i = 1'b0;
    applyStimulus(1, 5, 0, 6, 1, 0, 'hBAD, 'h55);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      checkOutput("raw_b_stall_bp", ready_o, 0);
      tick();
    end
    ready_i = 1'b1;
    @(negedge clk_i);
    checkOutput("raw_b_stall_held", ready_o, 0);
    tick();
    ex_fwd_we_i = 1'b1; ex_fwd_addr_i = 5; ex_fwd_data_i = 'hDEAD;
    exp_q.push_back(mk('hDEAD, 0, 6, 1, 0));
    @(negedge clk_i);
    checkOutput("raw_b_ready", ready_o, 1);
    tick();

    // Long load to x7, reader waits for ll_done
    ex_fwd_we_i = 1'b0;
    applyStimulus(1, 1, 2, 7, 1, 1, 'h10, 'h20);
    exp_q.push_back(mk('h10, 'h20, 7, 1, 1));
    @(negedge clk_i);
    checkOutput("ll_issue", ready_o, 1);
    tick();
    applyStimulus(1, 7, 3, 8, 1, 0, 'h77, 'h33);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      checkOutput("ll_wait", ready_o, 0);
      tick();
    end
    ll_done_i = 1'b1; ll_done_addr_i = 7;
    exp_q.push_back(mk('h77, 'h33, 8, 1, 0));
    @(negedge clk_i);
    checkOutput("ll_done_ready", ready_o, 1);
    tick();
    ll_done_i = 1'b0;
    applyStimulus(1, 7, 7, 9, 0, 0, 'h77, 'h78);
    exp_q.push_back(mk('h77, 'h78, 9, 0, 0));
    @(negedge clk_i);
    checkOutput("ll_cleared", ready_o, 1);
    tick();

    // x0 sources ignore forwarding; long write to x0 leaves nothing pending
    ex_fwd_we_i = 1'b1; ex_fwd_addr_i = 0; ex_fwd_data_i = 'hFF;
    applyStimulus(1, 0, 0, 0, 1, 1, 'h12, 'h34);
    exp_q.push_back(mk(0, 0, 0, 1, 1));
    @(negedge clk_i);
    checkOutput("x0_ready", ready_o, 1);
    tick();
    ex_fwd_we_i = 1'b0;
    applyStimulus(1, 0, 0, 0, 1, 0, 'h99, 'h98);
    exp_q.push_back(mk(0, 0, 0, 1, 0));
    @(negedge clk_i);
    checkOutput("x0_nosb", ready_o, 1);
    tick();

    // Backpressure
    applyStimulus(1, 3, 4, 11, 1, 0, 'h1111, 'h2222);
    exp_q.push_back(mk('h1111, 'h2222, 11, 1, 0));
    @(negedge clk_i);
    checkOutput("bp_issue", ready_o, 1);
    tick();
    ready_i = 1'b0;
    applyStimulus(1, 12, 13, 14, 1, 0, 'h3333, 'h4444);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checkOutput("bp_ready", ready_o, 0);
      checkOutput("bp_valid", valid_o, 1);
      checkOutput("bp_op1", op1_o, 'h1111);
      checkOutput("bp_op2", op2_o, 'h2222);
      checkOutput("bp_rd", rd_o, 11);
      tick();
    end
    ready_i = 1'b1;
    exp_q.push_back(mk('h3333, 'h4444, 14, 1, 0));
    @(negedge clk_i);
    checkOutput("bp_release", ready_o, 1);
    tick();

    // Flush a held long op to x9
    applyStimulus(1, 1, 2, 9, 1, 1, 'h5, 'h6);
    @(negedge clk_i);
    checkOutput("fl_issue", ready_o, 1);
    tick();
    ready_i = 1'b0; flush_i = 1'b1; valid_i = 1'b0;
    @(negedge clk_i);
    checkOutput("fl_ready", ready_o, 0);
    tick();
    flush_i = 1'b0; ready_i = 1'b1;
    applyStimulus(1, 9, 0, 10, 1, 0, 'h99, 'h1);
    exp_q.push_back(mk('h99, 0, 10, 1, 0));
    @(negedge clk_i);
    checkOutput("fl_valid", valid_o, 0);
    checkOutput("fl_sb_clear", ready_o, 1);
    tick();

    // Set/clear collision on x12
    applyStimulus(1, 1, 2, 12, 1, 1, 'h7, 'h8);
    exp_q.push_back(mk('h7, 'h8, 12, 1, 1));
    @(negedge clk_i);
    checkOutput("col_issue", ready_o, 1);
    tick();
    ll_done_i = 1'b1; ll_done_addr_i = 12;
    applyStimulus(1, 12, 0, 13, 1, 0, 'hC, 'h0);
    @(negedge clk_i);
    checkOutput("col_held", ready_o, 0);
    tick();
    ll_done_i = 1'b0;
    @(negedge clk_i);
    checkOutput("col_set_wins", ready_o, 0);
    tick();
    ll_done_i = 1'b1;
    exp_q.push_back(mk('hC, 0, 13, 1, 0));
    @(negedge clk_i);
    checkOutput("col_clear", ready_o, 1);
    tick();
    ll_done_i = 1'b0; valid_i = 1'b0;

    for (int i = 0; i < 3; i++) tick();
    checkOutput("drain_empty", exp_q.size(), 0);
    checkOutput("drain_valid", valid_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Issue stage directly upstream of the execute unit and the consumer of the integer register file's two read ports.
- Drives the register file read addresses from the decoded instruction.
- Selects each operand from x0, the EX forward bus or register file data, and tracks pending long-latency destinations (loads, mul/div) in a scoreboard.
- Holds one instruction in an output register under a valid/ready handshake, stalling upstream on hazards.

Parameters:
DATA_WIDTH, 64, operand/data width
ADDR_WIDTH, 5, register index width
REG_DEPTH, 32, number of architectural registers (scoreboard bits)

Ports:
clk_i  in  1  clock
arst_i  in  1  reset
valid_i  in  1  decoded instruction valid
ready_o  out  1  stage accepts instruction this cycle
rs1_i  in  ADDR_WIDTH  source 1 index
rs2_i  in  ADDR_WIDTH  source 2 index
rd_i  in  ADDR_WIDTH  destination index
rd_we_i  in  1  instruction writes rd
long_i  in  1  rd produced by long-latency unit
rf_addr_1_o  out  ADDR_WIDTH  register file read address 1 (= rs1_i, combinational)
rf_addr_2_o  out  ADDR_WIDTH  register file read address 2 (= rs2_i, combinational)
rf_data_1_i  in  DATA_WIDTH  register file read data 1 (already write-through)
rf_data_2_i  in  DATA_WIDTH  register file read data 2
ex_fwd_we_i  in  1  EX result valid this cycle
ex_fwd_addr_i  in  ADDR_WIDTH  EX result destination
ex_fwd_data_i  in  DATA_WIDTH  EX result
ll_done_i  in  1  long-latency write completes this cycle
ll_done_addr_i  in  ADDR_WIDTH  completing destination
flush_i  in  1  kill held instruction
valid_o  out  1  output register valid
ready_i  in  1  execute accepts
op1_o  out  DATA_WIDTH  operand 1
op2_o  out  DATA_WIDTH  operand 2
rd_o  out  ADDR_WIDTH  destination
rd_we_o  out  1  destination write enable
long_o  out  1  long-latency flag

Behaviour:
- Reset: one clock, clk_i. arst_i is a synchronous, active-high reset sampled on the rising edge of clk_i. On reset: valid_o=0, op1_o=op2_o=0, rd_o=0, rd_we_o=0, long_o=0, all scoreboard bits 0.
- Scoreboard: REG_DEPTH bits; bit 0 is never set.
  - Set bit rd_o on a downstream handshake (valid_o & ready_i) when rd_we_o & long_o & rd_o!=0.
  - Clear bit ll_done_addr_i when ll_done_i.
  - Same-cycle set and clear of the same index: set wins.
- busy(r): r!=0 & ((sb[r] & !(ll_done_i & ll_done_addr_i==r)) | (valid_o & rd_we_o & rd_o==r)). The same-cycle ll_done is bypassed; any held producer blocks.
- hazard = busy(rs1_i) | busy(rs2_i) | busy(rd_i) & rd_we_i. The rd term gives the WAW check.
- Readiness: ready_o = !flush_i & !hazard & (!valid_o | ready_i). ready_o is combinational and is independent of valid_i.
- Operand select, per source, in priority order:
  - index==0 -> 0;
  - ex_fwd_we_i & ex_fwd_addr_i==index -> ex_fwd_data_i;
  - otherwise rf_data.
- Forwarding contract: a short-latency result is visible on the EX bus or the register file write port in the cycle after it leaves this stage.
- Accept (valid_i & ready_o): at the next edge, capture the selected operands, rd, rd_we and long; valid_o=1. Latency is 1 cycle from accept to valid_o.
- Downstream handshake without a new accept: valid_o falls to 0.
- valid_o & !ready_i: all outputs hold stable.
- flush_i: valid_o=0 at the next edge; no accept that cycle. The scoreboard is unchanged, because issued long ops still complete.
- Reset mid-stall or with valid_o=1: the reset state wins; the scoreboard is cleared.

Test Plan:
- Reset, then issue rs1=3 and rs2=4 with rf_data 0x11/0x22 and ready_i=1 -> next cycle valid_o=1, op1_o=0x11, op2_o=0x22; outputs 0 while arst_i=1.
- Back-to-back short RAW: A writes x5 (rd_we_i=1), B reads x5 -> B stalls exactly while A is held (ready_o=0). B accepts the cycle A is in EX with ex_fwd_addr_i=5, data 0xDEAD -> op1_o=0xDEAD.
- Long load to x7 issued, ll_done_i after 4 cycles: reader of x7 has ready_o=0 until the cycle ll_done_i=1 with ll_done_addr_i=7. It accepts that same cycle, and sb[7]=0 afterwards.
- Sources x0 with ex_fwd_addr_i=0 and ex_fwd_data_i=0xFF -> op1_o=op2_o=0. A long write to x0 never sets the scoreboard.
- Backpressure: ready_i=0 for 3 cycles with valid_o=1 -> outputs hold, ready_o=0. On release, a new instruction is captured in the same cycle.
- flush_i with a held long op to x9 -> valid_o=0 next cycle and sb[9] stays 0. Set/clear collision on the same index -> the bit stays 1.
